// File: rtl/mmc_scanline_irq_pkg.sv
// Shared encodings for the MMC3-family scanline/cycle IRQ unit: register
// select codes, save-state register indices and flag bit positions.
package mmc_irq_pkg;

    // Decoded $C000-$FFFF register selects.
    typedef enum logic [1:0] {
        SEL_LATCH   = 2'd0,  // load reload latch from reg_dat
        SEL_RELOAD  = 2'd1,  // request reload on the next count event
        SEL_DISABLE = 2'd2,  // disable IRQ and acknowledge pending IRQ
        SEL_ENABLE  = 2'd3   // enable IRQ
    } reg_sel_e;

    // Save-state register map.
    localparam logic [2:0] SS_CTR_L = 3'd0;
    localparam logic [2:0] SS_CTR_H = 3'd1;
    localparam logic [2:0] SS_LAT_L = 3'd2;
    localparam logic [2:0] SS_LAT_H = 3'd3;
    localparam logic [2:0] SS_FLAGS = 3'd4;
    localparam logic [2:0] SS_PRESC = 3'd5;

    // Bit positions inside the SS_FLAGS byte.
    localparam int FLAG_RELOAD = 0;
    localparam int FLAG_PEND   = 1;
    localparam int FLAG_IRQ_ON = 2;

endpackage

// File: rtl/mmc_scanline_irq_if.sv
// Mapper-side bus of the IRQ unit: PPU A12 input, decoded register writes,
// mode controls, save-state port and the readback/IRQ outputs.
interface mmc_scanline_irq_if #(
    parameter int CTR_W = 8
) ();
    logic             ppu_a12;
    logic             reg_we;
    logic [1:0]       reg_sel;
    logic [CTR_W-1:0] reg_dat;
    logic             cyc_mode;
    logic             mmc3b_mode;
    logic             ss_act;
    logic             ss_we;
    logic [2:0]       ss_addr;
    logic [7:0]       ss_din;
    logic [7:0]       ss_rdat;
    logic [CTR_W-1:0] ctr_out;
    logic             irq;

    // Mapper top side.
    modport master (
        output ppu_a12, reg_we, reg_sel, reg_dat, cyc_mode, mmc3b_mode,
               ss_act, ss_we, ss_addr, ss_din,
        input  ss_rdat, ctr_out, irq
    );

    // IRQ unit side.
    modport slave (
        input  ppu_a12, reg_we, reg_sel, reg_dat, cyc_mode, mmc3b_mode,
               ss_act, ss_we, ss_addr, ss_din,
        output ss_rdat, ctr_out, irq
    );
endinterface

// File: rtl/mmc_scanline_irq_a12_edge_filter.sv
// PPU A12 rise detector: a rise counts only when the previous FILT_N samples
// were all low, which rejects the short A12 toggles inside a fetch group.
module a12_edge_filter #(
    parameter int FILT_N = 4
) (
    input  logic m2,
    input  logic map_rst,
    input  logic ppu_a12,
    input  logic hold,
    output logic evt_a12
);

    logic [FILT_N-1:0] hist_q;
    logic [FILT_N-1:0] hist_d;

    // Shift the newest sample in; the cast drops the oldest sample and also
    // covers FILT_N == 1 without a zero-width slice.
    always_comb begin
        hist_d = hold ? hist_q : FILT_N'({hist_q, ppu_a12});
    end

    // History register; reset to all ones so the first rise after reset
    // must be preceded by FILT_N low samples.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge.
    always_ff @(negedge m2 or posedge map_rst) begin
        if (map_rst) begin
            hist_q <= '1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign evt_a12 = !hold && ppu_a12 && (hist_q == '0);

endmodule

// File: rtl/mmc_scanline_irq.sv
// Scanline/cycle IRQ unit for MMC3-family mappers: reload counter driven by
// filtered A12 rises or prescaled M2 cycles, MMC3A/MMC3B reload semantics,
// registered IRQ output and a byte-wide save-state port.
module mmc_scanline_irq
    import mmc_irq_pkg::*;
#(
    parameter int CTR_W    = 8,
    parameter int FILT_N   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                m2,
    input  logic                map_rst,
    mmc_scanline_irq_if.slave   bus
);

    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [CTR_W-1:0] latch_q, latch_d;
    logic             irq_on_q, irq_on_d;
    logic             pend_q, pend_d;
    logic             reload_q, reload_d;
    logic [7:0]       presc_q, presc_d;

    logic             evt_a12;
    logic             evt_cyc;
    logic             evt;
    logic             ctr_zero;
    logic             do_reload;
    logic             auto_only;
    logic [CTR_W-1:0] new_ctr;
    logic [15:0]      ctr_ext;
    logic [15:0]      lat_ext;
    reg_sel_e         sel;

    a12_edge_filter #(.FILT_N(FILT_N)) u_filter (
        .m2      (m2),
        .map_rst (map_rst),
        .ppu_a12 (bus.ppu_a12),
        .hold    (bus.ss_act),
        .evt_a12 (evt_a12)
    );

    assign sel       = reg_sel_e'(bus.reg_sel);
    assign evt_cyc   = bus.cyc_mode && (presc_q == PRESC_LAST);
    assign evt       = !bus.ss_act && (bus.cyc_mode ? evt_cyc : evt_a12);
    assign ctr_zero  = (ctr_q == '0);
    assign do_reload = reload_q || ctr_zero;
    // A reload caused only by the counter reaching zero (no pending request):
    // MMC3A does not fire on this, MMC3B does.
    assign auto_only = ctr_zero && !reload_q;
    assign new_ctr   = do_reload ? latch_q : ctr_q - CTR_W'(1);

    // Next-state: count event first, then register writes so writes win;
    // while a save-state is active only save-state writes apply.
    // NOTE: every variable driven here gets a default first, otherwise
    // paths that skip an assignment would infer latches.
    always_comb begin
        ctr_d    = ctr_q;
        latch_d  = latch_q;
        irq_on_d = irq_on_q;
        pend_d   = pend_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        ctr_ext  = 16'(ctr_q);
        lat_ext  = 16'(latch_q);

        if (!bus.ss_act) begin
            if (!bus.cyc_mode || presc_q >= PRESC_LAST) begin
                presc_d = 8'd0;
            end else begin
                presc_d = presc_q + 8'd1;
            end

            if (evt) begin
                ctr_d = new_ctr;
                if (do_reload) begin
                    reload_d = 1'b0;
                end
                if (irq_on_q && new_ctr == '0 && (bus.mmc3b_mode || !auto_only)) begin
                    pend_d = 1'b1;
                end
            end

            if (bus.reg_we) begin
                case (sel)
                    SEL_LATCH: latch_d = bus.reg_dat;
                    SEL_RELOAD: begin
                        reload_d = 1'b1;
                        presc_d  = 8'd0;
                        ctr_d    = '0;
                    end
                    SEL_DISABLE: begin
                        irq_on_d = 1'b0;
                        pend_d   = 1'b0;
                    end
                    SEL_ENABLE: irq_on_d = 1'b1;
                    default: ;
                endcase
            end
        end else if (bus.ss_we) begin
            case (bus.ss_addr)
                SS_CTR_L: begin
                    ctr_ext[7:0] = bus.ss_din;
                    ctr_d        = ctr_ext[CTR_W-1:0];
                end
                SS_CTR_H: begin
                    ctr_ext[15:8] = bus.ss_din;
                    ctr_d         = ctr_ext[CTR_W-1:0];
                end
                SS_LAT_L: begin
                    lat_ext[7:0] = bus.ss_din;
                    latch_d      = lat_ext[CTR_W-1:0];
                end
                SS_LAT_H: begin
                    lat_ext[15:8] = bus.ss_din;
                    latch_d       = lat_ext[CTR_W-1:0];
                end
                SS_FLAGS: begin
                    irq_on_d = bus.ss_din[FLAG_IRQ_ON];
                    pend_d   = bus.ss_din[FLAG_PEND];
                    reload_d = bus.ss_din[FLAG_RELOAD];
                end
                SS_PRESC: presc_d = bus.ss_din;
                default: ;
            endcase
        end
    end

    // State registers, updated on the falling edge of M2.
    always_ff @(negedge m2 or posedge map_rst) begin
        if (map_rst) begin
            ctr_q    <= '0;
            latch_q  <= '0;
            irq_on_q <= 1'b0;
            pend_q   <= 1'b0;
            reload_q <= 1'b0;
            presc_q  <= 8'd0;
        end else begin
            ctr_q    <= ctr_d;
            latch_q  <= latch_d;
            irq_on_q <= irq_on_d;
            pend_q   <= pend_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
        end
    end

    // Save-state readback; bits above CTR_W read as zero.
    always_comb begin
        bus.ss_rdat = 8'hFF;
        case (bus.ss_addr)
            SS_CTR_L: bus.ss_rdat = 8'(16'(ctr_q));
            SS_CTR_H: bus.ss_rdat = 8'(16'(ctr_q) >> 8);
            SS_LAT_L: bus.ss_rdat = 8'(16'(latch_q));
            SS_LAT_H: bus.ss_rdat = 8'(16'(latch_q) >> 8);
            SS_FLAGS: bus.ss_rdat = {5'b0, irq_on_q, pend_q, reload_q};
            SS_PRESC: bus.ss_rdat = presc_q;
            default:  bus.ss_rdat = 8'hFF;
        endcase
    end

    assign bus.ctr_out = ctr_q;
    assign bus.irq     = pend_q;

endmodule

// File: doc/mmc_scanline_irq.md
Name: mmc_scanline_irq

Overview:
Parametrised scanline/cycle IRQ unit for MMC3-family mappers. It generalises the A12-driven counter found inside each MMC3-style mapper into a standalone block: configurable counter width, A12 filter depth, runtime MMC3A/MMC3B reload semantics, an optional prescaled CPU-cycle counting mode, and a registered IRQ output. It is instantiated by the mapper top and fed by its decoded $C000-$FFFF register writes and save-state bus.

Parameters:
CTR_W, 8, counter/latch width; legal range 8..16.
FILT_N, 4, number of consecutive low A12 samples required before a rising A12 counts; legal range 1..8.
PRESCALE, 4, M2 cycles per count event in cycle mode; legal range 1..256.

Ports:
m2  in  1  mapper clock; all state updates on the falling edge.
map_rst  in  1  reset, asynchronous, active-high.
ppu_a12  in  1  PPU address bit 12.
reg_we  in  1  register write strobe, one m2 cycle wide.
reg_sel  in  2  0=latch write, 1=reload request, 2=disable+acknowledge, 3=enable.
reg_dat  in  CTR_W  write data; latch value for sel 0.
cyc_mode  in  1  0=count filtered A12 rises, 1=count prescaled M2 cycles.
mmc3b_mode  in  1  1=MMC3B reload semantics, 0=MMC3A.
ss_act  in  1  save-state active; freezes normal operation.
ss_we  in  1  save-state write strobe.
ss_addr  in  3  save-state register index.
ss_din  in  8  save-state write data.
ss_rdat  out  8  save-state read data, combinational.
ctr_out  out  CTR_W  current counter value, for debug/readback.
irq  out  1  interrupt request, registered.

Behaviour:
- Reset (async): ctr=0, latch=0, irq_on=0, pend=0, reload_req=0, prescaler=0, filter history all ones. irq=0 immediately.
- Filter: FILT_N-bit shift of sampled ppu_a12 on every edge. A12 event = ppu_a12==1 AND all FILT_N history bits 0.
- Cycle mode: prescaler counts 0..PRESCALE-1 and wraps. Cycle event when prescaler==PRESCALE-1. Prescaler holds 0 while cyc_mode=0.
- evt = cyc_mode ? cycle event : A12 event.
- reload = reload_req | (ctr==0). auto_only = (ctr==0) & !reload_req.
- On evt:
  - If reload: ctr<=latch and reload_req<=0.
  - Else: ctr<=ctr-1.
  - new_ctr is the value written. pend<=1 when irq_on & new_ctr==0 & (mmc3b_mode | !auto_only).
  - Consequence: MMC3B with latch 0 fires on every evt. MMC3A with latch 0 fires once per reload request.
- Register writes (reg_we), applied in the same edge after evt processing; writes win on conflict:
  - sel0: latch<=reg_dat.
  - sel1: reload_req<=1, prescaler<=0, ctr<=0.
  - sel2: irq_on<=0, pend<=0. Overrides a pend set by a simultaneous evt.
  - sel3: irq_on<=1. pend is unchanged.
- irq = pend (registered). Asserts on the falling edge where the firing evt occurs and holds until sel2 or reset.
- ss_act=1: filter, prescaler, counter and register writes are frozen.
- Save-state writes (ss_we & ss_act):
  - addr0 ctr[7:0], addr1 ctr[15:8], addr2 latch[7:0], addr3 latch[15:8].
  - addr4 {5'b0, irq_on, pend, reload_req}.
  - addr5 prescaler[7:0].
  - Bits above CTR_W are ignored on write and read 0.
- ss_rdat mirrors the same map. addr6/7 read 8'hFF.
- map_rst asserted mid-count aborts the count and clears pend at once. The first A12 rise after release counts only after FILT_N low samples.

Decomposition:
- Package mmc_irq_pkg: reg_sel encodings (SEL_LATCH, SEL_RELOAD, SEL_DISABLE, SEL_ENABLE), save-state index constants (SS_CTR_L .. SS_PRESC), flag bit positions.
- Sub-module a12_edge_filter #(FILT_N): in m2, map_rst, ppu_a12, hold (=ss_act); out evt_a12.
- Prescaler and counter stay in the top module.

Test Plan:
- A12 counting: latch=3, sel1, sel3, four A12 pulses each preceded by 6 low cycles -> ctr 3,2,1,0; irq rises on the 4th pulse edge, not before; sel2 -> irq=0.
- Filter: FILT_N=4, A12 highs separated by 2 low cycles -> only the first rise counts, so ctr decrements once per burst.
- Zero latch: latch=0, sel1, sel3; mmc3b_mode=1 -> irq re-sets on every event after each sel2. mmc3b_mode=0 -> irq once; after sel2, further events leave irq=0.
- Cycle mode: PRESCALE=4, latch=2, sel1, sel3, cyc_mode=1 -> reload at M2 edge 4, ctr=1 at 8, ctr=0 and irq=1 at edge 12.
- Conflict: sel2 write on the same edge the counter hits 0 -> irq stays 0, pend=0. sel1 on the same edge as an evt -> reload_req=1 and ctr=0 afterward.
- Save-state and reset: ss_act=1, write addr0=5 and addr4=3'b110 -> ctr_out=5, irq=1; A12 pulses cause no change; readback matches, addr7=FF. Assert map_rst mid-count -> irq=0 and ctr=0 asynchronously.
